// File: rtl/decode_pkg.sv
// Shared opcode map, format codes and decoded-entry layout for the RV32I/RV64I decode stage.
// Combinational helpers only; no state.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYS    = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_t;

  // XLEN-independent part of a decoded entry; imm and pc travel beside it.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    fmt_t       fmt;
    logic       rd_we;
    logic       rs1_used;
    logic       rs2_used;
    logic       illegal;
  } dec_t;

  // Opcodes with bits[1:0] != 2'b11 never match the table, so they fall to FMT_ILL.
  function automatic fmt_t decode_fmt(input logic [6:0] op);
    fmt_t f;
    case (op)
      OP_R:                              f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS:  f = FMT_I;
      OP_STORE:                          f = FMT_S;
      OP_BRANCH:                         f = FMT_B;
      OP_LUI, OP_AUIPC:                  f = FMT_U;
      OP_JAL:                            f = FMT_J;
      default:                           f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the XLEN sign-extended immediate for a given format.
// Purely combinational, zero latency; no flow control.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction_i,
  input  fmt_t            fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic unused_opcode;
  assign unused_opcode = ^instruction_i[6:0];

  // Fill with the sign first, then overwrite the low bits that carry the field.
  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FMT_I: begin
        imm_o       = {XLEN{instruction_i[31]}};
        imm_o[11:0] = instruction_i[31:20];
      end
      FMT_S: begin
        imm_o       = {XLEN{instruction_i[31]}};
        imm_o[11:0] = {instruction_i[31:25], instruction_i[11:7]};
      end
      FMT_B: begin
        imm_o       = {XLEN{instruction_i[31]}};
        imm_o[12:0] = {instruction_i[31], instruction_i[7], instruction_i[30:25],
                       instruction_i[11:8], 1'b0};
      end
      FMT_U: begin
        imm_o       = {XLEN{instruction_i[31]}};
        imm_o[31:0] = {instruction_i[31:12], 12'b0};
      end
      FMT_J: begin
        imm_o       = {XLEN{instruction_i[31]}};
        imm_o[20:0] = {instruction_i[31], instruction_i[19:12], instruction_i[20],
                       instruction_i[30:21], 1'b0};
      end
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered instruction decode: fields, format, immediate, usage flags; 1-cycle latency.
// valid/ready output register; in_ready = !out_valid || out_ready, flush kills held and incoming entries.
module instruction_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            rd_we,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            illegal,
  output logic [XLEN-1:0] pc
);

  dec_t            dec_d, dec_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic [XLEN-1:0] pc_q;
  logic            out_valid_q;
  logic            accept;
  fmt_t            fmt_dec;

  assign fmt_dec = decode_fmt(in_instruction[6:0]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction_i (in_instruction),
    .fmt_i         (fmt_dec),
    .imm_o         (imm_d)
  );

  always_comb begin
    dec_d          = '0;
    dec_d.opcode   = in_instruction[6:0];
    dec_d.rd       = in_instruction[11:7];
    dec_d.funct3   = in_instruction[14:12];
    dec_d.rs1      = in_instruction[19:15];
    dec_d.rs2      = in_instruction[24:20];
    dec_d.funct7   = in_instruction[31:25];
    dec_d.fmt      = fmt_dec;
    dec_d.illegal  = (fmt_dec == FMT_ILL);
    dec_d.rd_we    = (fmt_dec inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (in_instruction[11:7] != 5'd0);
    dec_d.rs1_used = fmt_dec inside {FMT_R, FMT_I, FMT_S, FMT_B};
    dec_d.rs2_used = fmt_dec inside {FMT_R, FMT_S, FMT_B};
    if (ILLEGAL_AS_NOP && dec_d.illegal) begin
      dec_d.rd = 5'd0;
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flush outranks accept and stall; reset outranks everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      dec_q       <= dec_d;
      imm_q       <= imm_d;
      pc_q        <= in_pc;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = dec_q.opcode;
  assign rd        = dec_q.rd;
  assign funct3    = dec_q.funct3;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign funct7    = dec_q.funct7;
  assign fmt       = dec_q.fmt;
  assign rd_we     = dec_q.rd_we;
  assign rs1_used  = dec_q.rs1_used;
  assign rs2_used  = dec_q.rs2_used;
  assign illegal   = dec_q.illegal;
  assign imm       = imm_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench: RV32 stage (illegal flagged only) and RV64 stage (illegal as NOP) share one input stream.
module tb_instruction_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_instruction, in_pc;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'h0, in_pc};

  logic        in_ready, out_valid;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, pc;
  fmt_t        fmt;
  logic        rd_we, rs1_used, rs2_used, illegal;

  logic        in_ready64, out_valid64;
  logic [6:0]  opcode64, funct7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  funct3_64;
  logic [63:0] imm64, pc64;
  fmt_t        fmt64;
  logic        rd_we64, rs1_used64, rs2_used64, illegal64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_decode_stage #(.XLEN(32), .ILLEGAL_AS_NOP(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm), .fmt(fmt),
    .rd_we(rd_we), .rs1_used(rs1_used), .rs2_used(rs2_used), .illegal(illegal), .pc(pc)
  );

  instruction_decode_stage #(.XLEN(64), .ILLEGAL_AS_NOP(1'b1)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instruction(in_instruction), .in_pc(in_pc64), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .opcode(opcode64), .rd(rd64),
    .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64), .funct7(funct7_64), .imm(imm64), .fmt(fmt64),
    .rd_we(rd_we64), .rs1_used(rs1_used64), .rs2_used(rs2_used64), .illegal(illegal64), .pc(pc64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] p);
    in_valid       = 1'b1;
    in_instruction = inst;
    in_pc          = p;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instruction = 32'h0; in_pc = 32'h0;

    // Reset: inputs presented are ignored, in_ready follows the equation.
    drive(32'hFFF10093, 32'h100);
    step();
    step();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_opcode", opcode, 0);
    check("rst_imm", imm, 0);
    check("rst_pc", pc, 0);
    check("rst_fmt", fmt, 0);
    check("rst_out_valid64", out_valid64, 0);

    reset = 1'b0;
    drive(32'hFFF10093, 32'h100);                     // addi x1,x2,-1
    step();
    check("addi_vld", out_valid, 1);
    check("addi_opcode", opcode, 7'h13);
    check("addi_rd", rd, 1);
    check("addi_rs1", rs1, 2);
    check("addi_fmt", fmt, FMT_I);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    check("addi_rd_we", rd_we, 1);
    check("addi_rs1_used", rs1_used, 1);
    check("addi_rs2_used", rs2_used, 0);
    check("addi_pc", pc, 32'h100);
    check("addi_pc64", pc64, 64'h100);

    drive(32'h00532423, 32'h104);                     // sw x5,8(x6)
    step();
    check("sw_fmt", fmt, FMT_S);
    check("sw_rs1", rs1, 6);
    check("sw_rs2", rs2, 5);
    check("sw_funct3", funct3, 3'b010);
    check("sw_imm", imm, 8);
    check("sw_rd_we", rd_we, 0);
    check("sw_rs1_used", rs1_used, 1);
    check("sw_rs2_used", rs2_used, 1);

    drive(32'hFE000EE3, 32'h108);                     // beq x0,x0,-4
    step();
    check("beq_fmt", fmt, FMT_B);
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    check("beq_funct7", funct7, 7'h7F);

    drive(32'h123450B7, 32'h10C);                     // lui x1,0x12345
    step();
    check("lui_fmt", fmt, FMT_U);
    check("lui_imm", imm, 32'h12345000);
    check("lui_imm64", imm64, 64'h12345000);
    check("lui_rd_we", rd_we, 1);
    check("lui_rs1_used", rs1_used, 0);

    drive(32'h800000B7, 32'h110);                     // lui x1,0x80000
    step();
    check("lui_neg_imm", imm, 32'h80000000);
    check("lui_neg_imm64", imm64, 64'hFFFFFFFF80000000);

    drive(32'h008000EF, 32'h114);                     // jal x1,8
    step();
    check("jal_fmt", fmt, FMT_J);
    check("jal_imm", imm, 8);
    check("jal_rd_we", rd_we, 1);

    drive(32'h002081B3, 32'h118);                     // add x3,x1,x2
    step();
    check("add_fmt", fmt, FMT_R);
    check("add_imm", imm, 0);
    check("add_rd", rd, 3);
    check("add_rs2_used", rs2_used, 1);
    check("add_rd_we", rd_we, 1);

    drive(32'h00000013, 32'h11C);                     // addi x0,x0,0: rd=0 so no write
    step();
    check("nop_rd_we", rd_we, 0);
    check("nop_illegal", illegal, 0);

    drive(32'h00000000, 32'h120);
    step();
    check("zero_illegal", illegal, 1);
    check("zero_fmt", fmt, FMT_ILL);
    check("zero_rd_we", rd_we, 0);
    check("zero_rs1_used", rs1_used, 0);
    check("zero_imm", imm, 0);

    drive(32'hFFFFFFFF, 32'h124);
    step();
    check("ones_illegal", illegal, 1);
    check("ones_fmt", fmt, FMT_ILL);
    check("ones_rd", rd, 5'h1F);
    check("ones_rd64_nop", rd64, 0);
    check("ones_rd_we", rd_we, 0);
    check("ones_rs2_used", rs2_used, 0);
    check("ones_illegal64", illegal64, 1);

    // Stall: hold sw at the input while the add sits in the output register.
    drive(32'h002081B3, 32'h200);
    step();
    out_ready = 1'b0;
    drive(32'h00532423, 32'h204);
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_vld", out_valid, 1);
      check("stall_pc", pc, 32'h200);
      check("stall_fmt", fmt, FMT_R);
      check("stall_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    step();
    check("release_pc", pc, 32'h204);
    check("release_fmt", fmt, FMT_S);
    drive(32'hFE000EE3, 32'h208);
    step();
    check("stream_pc", pc, 32'h208);
    check("stream_vld", out_valid, 1);
    in_valid = 1'b0;
    step();
    check("drain_vld", out_valid, 0);

    // Flush while stalled with a new input offered.
    drive(32'h123450B7, 32'h300);
    step();
    out_ready = 1'b0;
    drive(32'h008000EF, 32'h304);
    flush = 1'b1;
    step();
    check("flush_stall_vld", out_valid, 0);
    check("flush_stall_vld64", out_valid64, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("flush_no_capture", out_valid, 0);

    // Flush with an empty stage: in_ready unaffected, input dropped.
    drive(32'h00532423, 32'h400);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1);
    step();
    check("flush_empty_vld", out_valid, 0);
    flush = 1'b0;
    step();
    check("after_flush_pc", pc, 32'h400);
    check("after_flush_vld", out_valid, 1);

    // Reset mid-stall (with flush also high) discards the held entry and clears outputs.
    drive(32'hFFF10093, 32'h500);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    check("pre_rst_vld", out_valid, 1);
    reset = 1'b1;
    flush = 1'b1;
    step();
    check("midrst_vld", out_valid, 0);
    check("midrst_opcode", opcode, 0);
    check("midrst_rd", rd, 0);
    check("midrst_imm", imm, 0);
    check("midrst_pc", pc, 0);
    check("midrst_rd_we", rd_we, 0);
    check("midrst_imm64", imm64, 0);
    reset = 1'b0;
    flush = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Registered RV32I/RV64I instruction decode stage between the IF/ID boundary and the register-file read / ID/EX register. It splits the 32-bit instruction into its fields, classifies the format, builds the sign-extended immediate at XLEN, and flags illegal opcodes. Results are held in an output register with a valid/ready handshake, stall backpressure and flush.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64. Sets the widths of `pc` and `imm`.
- ILLEGAL_AS_NOP, 0: when 1, an illegal instruction is forwarded with `rd`=0 and the write-enable flag cleared, in addition to being flagged.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: instruction and PC are valid.
- `in_ready` out 1: the stage can accept an input this cycle.
- `in_instruction` in 32: fetched instruction.
- `in_pc` in XLEN: PC of the instruction.
- `flush` in 1: kill the held entry and any entry being accepted this cycle.
- `out_valid` out 1: decoded entry is valid.
- `out_ready` in 1: the downstream stage accepts the entry.
- `opcode` out 7, `rd` out 5, `funct3` out 3, `rs1` out 5, `rs2` out 5, `funct7` out 7: raw instruction fields.
- `imm` out XLEN: sign-extended immediate.
- `fmt` out 3: format code (`fmt_t`).
- `rd_we` out 1: the instruction writes `rd` and `rd` != 0.
- `rs1_used`, `rs2_used` out 1 each: the source register is read.
- `illegal` out 1: unrecognised opcode.
- `pc` out XLEN: registered PC.

## Operation
Field extraction:
- `opcode`[6:0], `rd`[11:7], `funct3`[14:12], `rs1`[19:15], `rs2`[24:20], `funct7`[31:25].
- Fields are always taken from the raw instruction bits, whatever the format.

Format by opcode:
- 0x33 → R.
- 0x13, 0x03, 0x67, 0x73 → I.
- 0x23 → S.
- 0x63 → B.
- 0x37, 0x17 → U.
- 0x6F → J.
- Anything else, including bits[1:0] != 2'b11 and 0x00000000 → ILL, with `illegal`=1.

Immediates (bit 31 sign-extended to XLEN):
- I: inst[31:20].
- S: {inst[31:25], inst[11:7]}.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U: {inst[31:12], 12'b0}, sign-extended when XLEN=64.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- R and ILL: 0.

Usage flags:
- `rd_we` = format in {R, I, U, J} and `rd` != 0.
- `rs1_used` = format in {R, I, S, B}.
- `rs2_used` = format in {R, S, B}.
- ILL: all three flags are 0. If ILLEGAL_AS_NOP=1, `rd` is also forced to 0.

Handshake:
- `in_ready` = !`out_valid` || `out_ready` (combinational; no bubble on a full-rate stream).
- Accept (load) = `in_valid` && `in_ready` && !`flush`.
- On accept, every output register loads the decoded values and `out_valid` is set to 1.
- On `out_valid` && `out_ready` with no accept, `out_valid` is set to 0.
- While `out_valid` && !`out_ready`, all outputs hold stable.
- `flush`: next cycle `out_valid`=0 and no input is loaded, even if `in_valid` is high. `in_ready` is unaffected by `flush`. Flush wins over accept and over stall.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 per cycle while `out_ready`=1.
- Reset: `out_valid`=0. All fields, `imm`, `pc`, `fmt`, flags and `illegal` reset to 0.
- `in_ready` during reset follows the equation, so it reads 1 because `out_valid`=0. Inputs presented while `reset`=1 are not loaded.
- Reset asserted mid-stall discards the held entry.
- Reset and flush asserted together: reset result applies.
- Data outputs are don't-care while `out_valid`=0, but they must not change while `out_valid`=1 and `out_ready`=0.
- Decode logic is purely combinational from `in_instruction`. The only state is the output register plus `out_valid`.

## Structure
- Package `decode_pkg`:
  - opcode localparams (OP_R=0x33, OP_IMM=0x13, OP_LOAD=0x03, OP_JALR=0x67, OP_SYS=0x73, OP_STORE=0x23, OP_BRANCH=0x63, OP_LUI=0x37, OP_AUIPC=0x17, OP_JAL=0x6F).
  - `typedef enum logic [2:0] fmt_t` {FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL}.
- Sub-module `imm_gen` (parameter XLEN): combinational; inputs instruction and fmt, output imm. Shared later with the branch unit.
- The top level holds field extraction, format decode, flag logic and the output register.

## Test plan
- `addi x1,x2,-1` (0xFFF10093), `out_ready`=1: after 1 cycle `out_valid`=1, `opcode`=0x13, `rd`=1, `rs1`=2, `fmt`=I, `imm`=0xFFFFFFFF, `rd_we`=1, `rs2_used`=0.
- `sw x5,8(x6)` (0x00532423): `fmt`=S, `rs1`=6, `rs2`=5, `imm`=8, `rd_we`=0, `rs1_used`=`rs2_used`=1.
- `beq x0,x0,-4` (0xFE000EE3): `imm`=0xFFFFFFFC. `lui x1,0x12345` (0x123450B7): `imm`=0x12345000. With XLEN=64, `lui` with 0x80000 gives `imm`=0xFFFFFFFF80000000.
- 0x00000000 and 0xFFFFFFFF: `illegal`=1, `fmt`=ILL, `rd_we`=0. With ILLEGAL_AS_NOP=1, `rd`=0.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1: `in_ready`=0 and outputs stable. On release, the next instruction loads in the same cycle and the stream shows no gap or duplicate.
- `flush` while stalled and while `in_valid`=1: next cycle `out_valid`=0 and the input is not captured. Reset asserted mid-stall: next cycle `out_valid`=0 and all outputs are 0.
